// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/display/pulse decodes; VGA_SYNC_DELAY_EN adds one sync register stage
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       pxclk,
   input  logic       reset,
   input  logic       en,
   output logic [9:0] Column,
   output logic [9:0] Row,
   output logic       Display,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       frame_start,
   output logic       line_end
);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
   // primed is low after reset so the first enabled edge decodes (0,0) instead of advancing past it
   logic       primed;
   logic [9:0] col_n, row_n;
   logic       hs_r, vs_r;
   logic       col_wrap;
   // next raster position
   always_comb begin
      col_wrap = {1'b0, Column} == H_LAST;
      col_n    = !primed ? 10'd0 : col_wrap ? 10'd0 : Column + 10'd1;
      row_n    = !primed ? 10'd0 : !col_wrap ? Row : ({1'b0, Row} == V_LAST) ? 10'd0 : Row + 10'd1;
   end
   // counters and decodes of the next position, so every output lines up with Column/Row
   always_ff @(posedge pxclk) begin
      if (reset) begin
         primed      <= 1'b0;
         Column      <= '0;
         Row         <= '0;
         Display     <= 1'b0;
         hs_r        <= 1'b1;
         vs_r        <= 1'b1;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else if (en) begin
         primed      <= 1'b1;
         Column      <= col_n;
         Row         <= row_n;
         Display     <= ({1'b0, col_n} < H_ACT) && ({1'b0, row_n} < V_ACT);
         hs_r        <= !(({1'b0, col_n} >= HS_BEG) && ({1'b0, col_n} < HS_END));
         vs_r        <= !(({1'b0, row_n} >= VS_BEG) && ({1'b0, row_n} < VS_END));
         frame_start <= (col_n == 10'd0) && (row_n == 10'd0);
         line_end    <= {1'b0, col_n} == H_LAST;
      end else begin
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end
   end
`ifdef VGA_SYNC_DELAY_EN
   logic hs_d, vs_d;
   // extra sync stage to match a registered RGB path
   always_ff @(posedge pxclk) begin
      if (reset) begin
         hs_d <= 1'b1;
         vs_d <= 1'b1;
      end else if (en) begin
         hs_d <= hs_r;
         vs_d <= vs_r;
      end
   end
   assign vga_h_sync = hs_d;
   assign vga_v_sync = vs_d;
`else
   assign vga_h_sync = hs_r;
   assign vga_v_sync = vs_r;
`endif
endmodule
